// File: rtl/monitor_dbg_pkg.sv
// Shared constants for the debug monitor PIO capture block.
//   - Avalon word addresses of the register map
//   - EDGE_TYPE and IRQ_TYPE parameter encodings
//   - edge_detect(): per-bit edge function selected by EDGE_TYPE
package monitor_dbg_pkg;

  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_RSVD    = 2'd1;
  localparam logic [1:0] ADDR_IRQMASK = 2'd2;
  localparam logic [1:0] ADDR_EDGECAP = 2'd3;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

  localparam int IRQ_LEVEL = 0;
  localparam int IRQ_EDGE  = 1;

  function automatic logic [31:0] edge_detect(input logic [31:0] cur,
                                              input logic [31:0] prev,
                                              input int          edge_type);
    logic [31:0] hit;
    case (edge_type)
      EDGE_RISE: hit = cur & ~prev;
      EDGE_FALL: hit = ~cur & prev;
      default:   hit = cur ^ prev;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/monitor_dbg_sync.sv
// Multi-stage flip-flop synchroniser for asynchronous debug inputs.
//   clk      in   system clock
//   reset_n  in   asynchronous active-low reset, clears every stage
//   d        in   WIDTH asynchronous inputs
//   q        out  WIDTH synchronised outputs (last stage of the chain)
module monitor_dbg_sync #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage [STAGES];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < STAGES; i++) begin
        stage[i] <= '0;
      end
    end else begin
      stage[0] <= d;
      for (int unsigned i = 1; i < STAGES; i++) begin
        stage[i] <= stage[i-1];
      end
    end
  end

  assign q = stage[STAGES-1];

endmodule

// File: rtl/monitor_dbg_pio_capture.sv
// Avalon-MM input PIO for the debug monitor with input synchronisation,
// per-bit edge capture (write-1-to-clear), interrupt mask and registered irq.
//   clk         in   system clock
//   reset_n     in   asynchronous active-low reset
//   address     in   register word address (0 DATA, 1 reserved, 2 IRQMASK, 3 EDGECAPTURE)
//   chipselect  in   slave select
//   write_n     in   active-low write strobe
//   writedata   in   32-bit write data
//   in_port     in   WIDTH external asynchronous inputs
//   readdata    out  registered read data, latency 1, upper bits zero
//   irq         out  registered interrupt request, active-high
module monitor_dbg_pio_capture
  import monitor_dbg_pkg::*;
#(
  parameter int          WIDTH       = 16,
  parameter int          SYNC_STAGES = 2,
  parameter int          EDGE_TYPE   = 0,
  parameter int          IRQ_TYPE    = 1,
  parameter logic [31:0] RESET_MASK  = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam logic [2:0] PRIME_DONE = 3'(SYNC_STAGES + 1);

  logic [WIDTH-1:0] sync;
  logic [WIDTH-1:0] prev;
  logic [WIDTH-1:0] edge_capture;
  logic [WIDTH-1:0] irq_mask;
  logic [2:0]       prime_cnt;
  logic             primed;
  logic             wr;
  logic [31:0]      edge_hit;
  logic [WIDTH-1:0] cap_set;
  logic [WIDTH-1:0] cap_clr;
  logic [31:0]      rd_next;
  logic             irq_next;
  logic             unused_bits;

  monitor_dbg_sync #(
    .WIDTH  (WIDTH),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (in_port),
    .q       (sync)
  );

  assign wr     = chipselect & ~write_n;
  assign primed = (prime_cnt == PRIME_DONE);

  // Priming holds edge detection off until the synchroniser and prev stage
  // hold real samples, so inputs static at reset release never capture.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prime_cnt <= '0;
    end else if (!primed) begin
      prime_cnt <= prime_cnt + 3'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev <= '0;
    end else begin
      prev <= sync;
    end
  end

  always_comb begin
    edge_hit = edge_detect(32'(sync), 32'(prev), EDGE_TYPE);
    cap_set  = primed ? edge_hit[WIDTH-1:0] : '0;
    cap_clr  = (wr && address == ADDR_EDGECAP) ? writedata[WIDTH-1:0] : '0;
  end

  // Set wins over clear for the same bit in the same cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      edge_capture <= '0;
    end else begin
      edge_capture <= (edge_capture & ~cap_clr) | cap_set;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_mask <= RESET_MASK[WIDTH-1:0];
    end else if (wr && address == ADDR_IRQMASK) begin
      irq_mask <= writedata[WIDTH-1:0];
    end
  end

  always_comb begin
    rd_next = '0;
    case (address)
      ADDR_DATA:    rd_next[WIDTH-1:0] = sync;
      ADDR_RSVD:    rd_next = '0;
      ADDR_IRQMASK: rd_next[WIDTH-1:0] = irq_mask;
      ADDR_EDGECAP: rd_next[WIDTH-1:0] = edge_capture;
      default:      rd_next = '0;
    endcase
  end

  always_comb begin
    if (IRQ_TYPE == IRQ_LEVEL) begin
      irq_next = |(sync & irq_mask);
    end else begin
      irq_next = |(edge_capture & irq_mask);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata <= '0;
      irq      <= 1'b0;
    end else begin
      readdata <= rd_next;
      irq      <= irq_next;
    end
  end

  // Upper write-data and edge bits are intentionally ignored when WIDTH < 32.
  assign unused_bits = ^{writedata, edge_hit};

endmodule

// File: tb/tb_monitor_dbg_pio_capture.sv
// Self-checking bench: two instances (defaults, and an 8-bit any-edge
// level-irq variant) share one bus and one input vector. A history-based
// reference model predicts readdata/irq every cycle; directed steps add
// constant expectations for the key latency and priority cases.
module tb_monitor_dbg_pio_capture;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  address = '0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [31:0] in_all = '0;
  logic [31:0] rd0, rd1;
  logic        irq0, irq1;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  monitor_dbg_pio_capture u_dut0 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_all[15:0]),
    .readdata(rd0), .irq(irq0)
  );

  monitor_dbg_pio_capture #(
    .WIDTH(8), .SYNC_STAGES(3), .EDGE_TYPE(2), .IRQ_TYPE(0), .RESET_MASK(32'h0F)
  ) u_dut1 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_all[7:0]),
    .readdata(rd1), .irq(irq1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int          cw [2] = '{16, 8};
  int          cs [2] = '{2, 3};
  int          ce [2] = '{0, 2};   // 0 rise, 1 fall, 2 any
  int          ci [2] = '{1, 0};   // 1 edge irq, 0 level irq
  logic [31:0] crm[2] = '{32'h0, 32'h0F};

  logic [31:0] hist[$];   // hist[i] = in_all sampled at edge i+1 after release
  int          e_cnt;
  logic [31:0] m_cap[2], m_mask[2], m_rd[2];
  logic        m_irq[2];

  function automatic logic [31:0] sample_at(input int i);
    return (i >= 1) ? hist[i-1] : 32'h0;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      e_cnt = 0;
      hist.delete();
      for (int c = 0; c < 2; c++) begin
        m_cap[c] = '0; m_mask[c] = crm[c]; m_rd[c] = '0; m_irq[c] = 1'b0;
      end
    end else begin
      e_cnt++;
      hist.push_back(in_all);
      for (int c = 0; c < 2; c++) begin
        logic [31:0] wm, s, p, hit, clr;
        wm = (cw[c] == 32) ? 32'hFFFF_FFFF : ((32'h1 << cw[c]) - 1);
        // Value visible on the synchronised output, and the one before it.
        s = sample_at(e_cnt - cs[c]) & wm;
        p = sample_at(e_cnt - cs[c] - 1) & wm;
        case (address)
          2'd0:    m_rd[c] = s;
          2'd2:    m_rd[c] = m_mask[c];
          2'd3:    m_rd[c] = m_cap[c];
          default: m_rd[c] = '0;
        endcase
        m_irq[c] = ci[c] ? |(m_cap[c] & m_mask[c]) : |(s & m_mask[c]);
        if (ce[c] == 0)      hit = s & ~p;
        else if (ce[c] == 1) hit = ~s & p;
        else                 hit = s ^ p;
        if (e_cnt < cs[c] + 2) hit = '0;
        clr = (chipselect && !write_n && address == 2'd3) ? (writedata & wm) : '0;
        m_cap[c] = (m_cap[c] & ~clr) | (hit & wm);
        if (chipselect && !write_n && address == 2'd2) m_mask[c] = writedata & wm;
      end
    end
  end

  always @(negedge clk) begin
    if (reset_n) begin
      check("model_rd0", rd0, m_rd[0]);
      check("model_irq0", {31'b0, irq0}, {31'b0, m_irq[0]});
      check("model_rd1", rd1, m_rd[1]);
      check("model_irq1", {31'b0, irq1}, {31'b0, m_irq[1]});
    end
  end

  // ---------------- bus helpers (call at a negedge) ----------------
  task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic bus_rd(input logic [1:0] a);
    address = a; chipselect = 1'b1; write_n = 1'b1;
    @(negedge clk);
    chipselect = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset / priming with inputs static high.
    in_all = 32'hFFFF_FFFF;
    address = 2'd3;
    repeat (3) @(negedge clk);
    check("reset_rd0", rd0, 32'h0);
    check("reset_irq0", {31'b0, irq0}, 32'h0);
    reset_n = 1'b1;
    repeat (10) @(negedge clk);
    check("prime_cap0", rd0, 32'h0);
    check("prime_cap1", rd1, 32'h0);
    check("prime_irq0", {31'b0, irq0}, 32'h0);
    bus_rd(2'd0);
    check("prime_data0", rd0, 32'h0000_FFFF);
    check("prime_data1", rd1, 32'h0000_00FF);
    bus_rd(2'd1);
    check("rsvd_rd0", rd0, 32'h0);

    // Rising capture latency.
    in_all = 32'h0;
    repeat (6) @(negedge clk);
    bus_wr(2'd3, 32'hFFFF_FFFF);
    bus_wr(2'd2, 32'h1);
    address = 2'd3;
    @(negedge clk);
    in_all = 32'h5;
    repeat (3) @(posedge clk);
    #1;
    check("lat_cap_early", rd0, 32'h0);
    check("lat_irq_early", {31'b0, irq0}, 32'h0);
    @(posedge clk);
    #1;
    check("lat_cap", rd0, 32'h5);
    check("lat_irq", {31'b0, irq0}, 32'h1);

    // W1C and set-over-clear priority.
    @(negedge clk);
    bus_wr(2'd3, 32'h4);
    bus_rd(2'd3);
    check("w1c_bit2", rd0, 32'h1);
    in_all = 32'h4;
    repeat (4) @(negedge clk);
    bus_wr(2'd3, 32'h1);
    bus_rd(2'd3);
    check("w1c_bit0", rd0, 32'h0);
    in_all = 32'h5;
    repeat (2) @(negedge clk);
    bus_wr(2'd3, 32'h1);
    bus_rd(2'd3);
    check("set_over_clr", rd0, 32'h1);

    // Mask gating.
    bus_wr(2'd3, 32'hFFFF_FFFF);
    bus_wr(2'd2, 32'h0);
    in_all = 32'h105;
    repeat (5) @(negedge clk);
    bus_rd(2'd3);
    check("mask_cap", rd0, 32'h100);
    check("mask_off_irq", {31'b0, irq0}, 32'h0);
    bus_wr(2'd2, 32'h100);
    check("mask_on_irq_lat", {31'b0, irq0}, 32'h0);
    @(negedge clk);
    check("mask_on_irq", {31'b0, irq0}, 32'h1);
    bus_wr(2'd2, 32'h0);
    check("mask_clr_irq_lat", {31'b0, irq0}, 32'h1);
    @(negedge clk);
    check("mask_clr_irq", {31'b0, irq0}, 32'h0);

    // 8-bit any-edge, level-irq variant.
    in_all = 32'h0;
    repeat (6) @(negedge clk);
    bus_wr(2'd3, 32'hFF);
    bus_rd(2'd3);
    check("w8_clear", rd1, 32'h0);
    in_all = 32'h81;
    repeat (6) @(negedge clk);
    bus_rd(2'd3);
    check("w8_rise", rd1, 32'h81);
    bus_wr(2'd3, 32'hFF);
    in_all = 32'h01;
    repeat (6) @(negedge clk);
    bus_rd(2'd3);
    check("w8_fall", rd1, 32'h80);
    bus_rd(2'd0);
    check("w8_data", rd1, 32'h01);
    bus_wr(2'd2, 32'h1);
    @(negedge clk);
    check("w8_lvl_irq_on", {31'b0, irq1}, 32'h1);
    in_all = 32'h0;
    repeat (5) @(negedge clk);
    check("w8_lvl_irq_off", {31'b0, irq1}, 32'h0);

    // Randomised traffic, checked by the model every cycle.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) == 0) in_all = $urandom;
      address    = 2'($urandom_range(0, 3));
      chipselect = 1'($urandom_range(0, 1));
      write_n    = ($urandom_range(0, 3) != 0);
      writedata  = $urandom;
      @(negedge clk);
    end
    chipselect = 1'b0; write_n = 1'b1;

    // Mid-operation reset.
    bus_wr(2'd2, 32'hFFFF_FFFF);
    bus_wr(2'd3, 32'hFFFF_FFFF);
    in_all = 32'h0;
    repeat (6) @(negedge clk);
    in_all = 32'hFFFF_FFFF;
    repeat (6) @(negedge clk);
    bus_rd(2'd3);
    check("pre_rst_cap", rd0, 32'hFFFF);
    check("pre_rst_irq", {31'b0, irq0}, 32'h1);
    #2;
    reset_n = 1'b0;
    #1;
    check("rst_rd0", rd0, 32'h0);
    check("rst_irq0", {31'b0, irq0}, 32'h0);
    check("rst_rd1", rd1, 32'h0);
    check("rst_irq1", {31'b0, irq1}, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (8) @(negedge clk);
    bus_rd(2'd3);
    check("post_rst_cap0", rd0, 32'h0);
    check("post_rst_cap1", rd1, 32'h0);
    bus_rd(2'd2);
    check("post_rst_mask0", rd0, 32'h0);
    check("post_rst_mask1", rd1, 32'h0F);

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/monitor_dbg_pio_capture.md
Name: monitor_dbg_pio_capture

Overview:
- Parametrised Avalon-MM input PIO for the debug monitor.
- Successor to the fixed 16-bit read-only data port; adds input synchronisation, per-bit edge capture with write-1-to-clear, an interrupt mask and a registered interrupt output.
- Sits on the monitor's Avalon bus as a slave, sampling external debug signals for the Nios monitor firmware.

Parameters:
- WIDTH, 16, number of input bits (legal 1..32).
- SYNC_STAGES, 2, flip-flop stages on in_port (legal 2..4).
- EDGE_TYPE, 0, capture edge: 0 = rising, 1 = falling, 2 = any.
- IRQ_TYPE, 1, interrupt source: 0 = level (data & mask), 1 = edge (capture & mask).
- RESET_MASK, 0, reset value of the irq mask register (WIDTH bits).

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- address  in  2  register word address
- chipselect  in  1  slave select
- write_n  in  1  active-low write strobe
- writedata  in  32  write data
- in_port  in  WIDTH  external asynchronous inputs
- readdata  out  32  registered read data
- irq  out  1  registered interrupt request, active-high

Behaviour:
- Reset and clock: reset_n is asynchronous, active-low; clock is clk; all flops are reset.
- Reset values:
  - readdata = 0, irq = 0.
  - Synchroniser stages = 0, prev stage = 0.
  - edge_capture = 0, irq_mask = RESET_MASK.
  - prime counter = 0.
- Address map:
  - 0 DATA: RO, synchronised input.
  - 1 reserved: reads 0, writes ignored.
  - 2 IRQMASK: RW, WIDTH bits.
  - 3 EDGECAPTURE: RW1C.
- Read path:
  - readdata is registered every cycle from the mux selected by address, regardless of chipselect; read latency 1.
  - Bits [31:WIDTH] always read 0.
- Synchroniser:
  - sync = last stage of a SYNC_STAGES chain; prev = sync delayed by one cycle.
  - Changes to in_port before edge k appear in sync after edge k+SYNC_STAGES-1.
- Edge detect:
  - Rising: sync & ~prev. Falling: ~sync & prev. Any: sync ^ prev.
  - The corresponding edge_capture bit sets at edge k+SYNC_STAGES.
- Prime counter:
  - After reset release, edge detection is gated off until the counter reaches SYNC_STAGES+1, then stays enabled.
  - This stops inputs that are static high/low at reset release from producing spurious captures.
  - The counter saturates and never wraps.
- Writes: write = chipselect & ~write_n.
  - Address 2 loads irq_mask <= writedata[WIDTH-1:0].
  - Address 3 clears each edge_capture bit where writedata is 1.
- Set vs clear: set has priority over clear for the same bit in the same cycle. The bit stays 1.
- Read of address 3 in the same cycle as a clear returns the pre-clear value.
- irq:
  - Registered. Next-state value is |(edge_capture & irq_mask) when IRQ_TYPE = 1, or |(sync & irq_mask) when IRQ_TYPE = 0.
  - irq asserts one cycle after the source bit sets, and deasserts one cycle after the clear or mask write.
- Reset mid-operation: reset_n low forces every flop to its reset value immediately; priming restarts on release.
- Writes while chipselect = 0 are ignored; writes to address 0 and 1 are ignored.

Decomposition:
- Package monitor_dbg_pkg holds:
  - Address constants: ADDR_DATA = 0, ADDR_IRQMASK = 2, ADDR_EDGECAP = 3.
  - EDGE_TYPE encodings: EDGE_RISE, EDGE_FALL, EDGE_ANY.
  - IRQ_TYPE encodings: IRQ_LEVEL, IRQ_EDGE.
- One sub-module: monitor_dbg_sync, a WIDTH-bit SYNC_STAGES-deep synchroniser with async reset to 0.
- Edge detect, registers, mux and irq stay in the top level.

Test Plan:
- Reset/priming: hold in_port = 16'hFFFF through reset release, wait 10 cycles -> EDGECAPTURE reads 0, DATA reads 32'h0000FFFF, irq = 0.
- Rising capture latency (defaults): after priming, in_port 0 -> 16'h0005 before edge k -> edge_capture = 16'h0005 after edge k+2; with irq_mask = 16'h0001, irq rises after edge k+3.
- W1C and priority: edge_capture = 16'h0005; write 32'h4 to address 3 -> reads 16'h0001. Write 32'h1 in the same cycle bit 0 sees a new rising edge -> bit 0 stays 1.
- Mask gating: edge_capture = 16'h0100, irq_mask = 0 -> irq = 0. Write 16'h0100 to address 2 -> irq = 1 one cycle later; writing 0 drops it one cycle later.
- Parameter sweep WIDTH = 8, EDGE_TYPE = 2, IRQ_TYPE = 0:
  - in_port 8'h00 -> 8'h81 -> 8'h01: bit 7 captured on rise and fall, bit 0 on rise.
  - readdata[31:8] = 0.
  - irq follows sync & mask.
- Mid-operation reset: assert reset_n low while irq = 1 and edge_capture != 0 -> readdata, irq and edge_capture = 0 immediately; irq_mask = RESET_MASK.
